// File: rtl/cfs_apb_master.sv
// Single-outstanding APB master: turns one command into one APB transfer and
// holds the response until the requester consumes it. Optional ACCESS timeout.
//
// state  | meaning
// IDLE   | waiting for a command, cmd_ready high
// SETUP  | psel=1, penable=0 for one cycle
// ACCESS | psel=1, penable=1 until pready or timeout
// RESP   | rsp_valid high until rsp_ready
module cfs_apb_master #(
  parameter int APB_ADDR_WIDTH = 16,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_write,
  input  logic [APB_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [APB_DATA_WIDTH-1:0] cmd_wdata,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata,
  output logic                      rsp_err,
  output logic                      rsp_timeout,
  output logic [APB_ADDR_WIDTH-1:0] paddr,
  output logic                      pwrite,
  output logic                      psel,
  output logic                      penable,
  output logic [APB_DATA_WIDTH-1:0] pwdata,
  input  logic                      pready,
  input  logic [APB_DATA_WIDTH-1:0] prdata,
  input  logic                      pslverr
);

  // Keep the counter at least one bit wide so TIMEOUT_CYCLES=0 still elaborates.
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] to_cnt;
  logic             done;
  logic             timed_out;

  always_ff @(posedge pclk) begin
    if (!presetn) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    psel      = 1'b0;
    penable   = 1'b0;
    rsp_valid = 1'b0;
    done      = 1'b0;
    timed_out = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = presetn;
        if (cmd_valid && presetn) state_nxt = SETUP;
      end
      SETUP: begin
        psel      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        // pready wins over a timeout landing in the same cycle
        if (pready) begin
          done      = 1'b1;
          state_nxt = RESP;
        end else if ((TIMEOUT_CYCLES != 0) && (to_cnt == TO_LAST)) begin
          timed_out = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      paddr       <= '0;
      pwrite      <= 1'b0;
      pwdata      <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      to_cnt      <= '0;
    end else begin
      if (cmd_ready && cmd_valid) begin
        paddr  <= cmd_addr;
        pwrite <= cmd_write;
        pwdata <= cmd_wdata;
      end
      if (state == SETUP)             to_cnt <= '0;
      else if (state == ACCESS && !pready) to_cnt <= to_cnt + 1'b1;
      if (done) begin
        rsp_rdata   <= pwrite ? '0 : prdata;
        rsp_err     <= pslverr;
        rsp_timeout <= 1'b0;
      end else if (timed_out) begin
        rsp_rdata   <= '0;
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
      end
    end
  end

endmodule

// File: doc/cfs_apb_master.md
CFS_APB_MASTER -- requirements
Module: cfs_apb_master

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 16, APB address width.
REQ-002 SHALL have parameter APB_DATA_WIDTH, default 32, APB data width.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum ACCESS cycles without pready; 0 disables the timeout.
REQ-004 SHALL have ports:
- pclk  in  1  clock; all logic on its rising edge.
- presetn  in  1  synchronous active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when high together with cmd_valid.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  APB_ADDR_WIDTH  target byte address.
- cmd_wdata  in  APB_DATA_WIDTH  write data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed when high together with rsp_valid.
- rsp_rdata  out  APB_DATA_WIDTH  read data.
- rsp_err  out  1  pslverr seen, or timeout.
- rsp_timeout  out  1  transfer aborted by timeout.
- paddr  out  APB_ADDR_WIDTH  APB address.
- pwrite  out  1  APB direction.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwdata  out  APB_DATA_WIDTH  APB write data.
- pready  in  1  APB ready.
- prdata  in  APB_DATA_WIDTH  APB read data.
- pslverr  in  1  APB error.

Function
REQ-005 SHALL implement the FSM states IDLE, SETUP, ACCESS and RESP.
REQ-006 SHALL drive cmd_ready=1 only in IDLE; all other states SHALL drive it 0.
REQ-007 On cmd_valid&cmd_ready, the block SHALL register cmd_write, cmd_addr and cmd_wdata into pwrite, paddr and pwdata, and move to SETUP.
REQ-008 In SETUP the block SHALL drive psel=1 and penable=0 for exactly one cycle, then move to ACCESS.
REQ-009 In ACCESS the block SHALL drive psel=1 and penable=1 until it samples pready=1.
REQ-010 The cmd_addr[1:0] bits SHALL be forwarded unmodified; paddr, pwrite and pwdata SHALL be stable from SETUP through the final ACCESS cycle.
REQ-011 On an ACCESS cycle with pready=1, the block SHALL register rsp_rdata = prdata for reads and 0 for writes, rsp_err = pslverr and rsp_timeout = 0; psel and penable SHALL be 0 on the next cycle; the FSM SHALL move to RESP.
REQ-012 Minimum command-accept-to-rsp_valid latency SHALL be 3 cycles (pready high in the first ACCESS cycle).
REQ-013 In RESP the block SHALL hold rsp_valid=1 and keep rsp_* stable until rsp_ready=1, then SHALL clear rsp_valid and return to IDLE.
REQ-014 rsp_valid and rsp_ready high in the same cycle SHALL complete the response; the next command SHALL be accepted no earlier than the following cycle, so APB transfers are never back-to-back without an idle cycle.
REQ-015 The timeout counter width SHALL be $clog2(TIMEOUT_CYCLES+1); the counter SHALL clear on entering ACCESS and increment on each ACCESS cycle with pready=0.
REQ-016 When the timeout counter reaches TIMEOUT_CYCLES while pready=0 (and TIMEOUT_CYCLES!=0), the block SHALL:
- deassert psel and penable on the next cycle;
- set rsp_err=1, rsp_timeout=1 and rsp_rdata=0;
- move to RESP.
REQ-017 pready=1 in the same cycle the counter reaches TIMEOUT_CYCLES SHALL be treated as normal completion, not as a timeout.
REQ-018 pready, prdata and pslverr SHALL be ignored outside ACCESS.
REQ-019 Outside SETUP and ACCESS the block SHALL drive psel=0 and penable=0; paddr, pwrite and pwdata SHALL hold their last values.

Reset
REQ-020 On a presetn=0 sample the block SHALL enter IDLE with:
- psel=0, penable=0, pwrite=0, paddr=0, pwdata=0;
- rsp_valid=0, rsp_rdata=0, rsp_err=0, rsp_timeout=0;
- timeout counter=0;
- cmd_ready=0 while presetn=0.
REQ-021 Reset during SETUP, ACCESS or RESP SHALL abort the transfer with no response; psel SHALL be 0 on the first edge at which presetn=0 is sampled.
REQ-022 After reset release, the first command SHALL be accepted on the first cycle with cmd_valid=1.

Verification
REQ-023 The bench SHALL cover write 0x00F0 data 0x1F with pready high on the 2nd ACCESS cycle -> psel high for 3 cycles, penable for 2; rsp_valid 4 cycles after accept; rsp_err=0; rsp_rdata=0.
REQ-024 The bench SHALL cover read 0x000C with prdata=0x00030207 and pready high on the 1st ACCESS cycle -> rsp_rdata=0x00030207, rsp_err=0, latency 3.
REQ-025 The bench SHALL cover write 0x0008 with pslverr=1 and pready=1 -> rsp_err=1, rsp_timeout=0.
REQ-026 The bench SHALL cover TIMEOUT_CYCLES=4 with pready held 0 -> exactly 4 ACCESS cycles, psel=0 next, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-027 The bench SHALL cover rsp_ready held 0 for 5 cycles while cmd_valid=1 -> rsp_* stable, cmd_ready=0, psel=0 throughout; the next command is accepted the cycle after the rsp handshake.
REQ-028 The bench SHALL cover presetn=0 for 1 cycle during ACCESS -> psel=penable=0 and rsp_valid=0 at that edge; no response is produced; a new command completes normally.
